// File: rtl/jk_edge_monitor_if.sv
// JK flip-flop edge monitor bus.
// Carries the sampled JK outputs, clear and all monitor results.
interface jk_edge_monitor_if #(
  parameter int CNT_W = 8
);
  logic             Q_IN;
  logic             Q_N_IN;
  logic             CLR;
  logic [CNT_W-1:0] RISE_CNT;
  logic [CNT_W-1:0] FALL_CNT;
  logic             RISE_P;
  logic             FALL_P;
  logic             TOGGLE_DET;
  logic             ERR;

  modport master (
    output Q_IN,
    output Q_N_IN,
    output CLR,
    input  RISE_CNT,
    input  FALL_CNT,
    input  RISE_P,
    input  FALL_P,
    input  TOGGLE_DET,
    input  ERR
  );

  modport slave (
    input  Q_IN,
    input  Q_N_IN,
    input  CLR,
    output RISE_CNT,
    output FALL_CNT,
    output RISE_P,
    output FALL_P,
    output TOGGLE_DET,
    output ERR
  );
endinterface

// File: rtl/jk_edge_monitor.sv
// JK flip-flop edge monitor: synchronizes Q/Q_N, counts edges,
// detects toggle mode and flags complement violations.
module jk_edge_monitor #(
  parameter int CNT_W    = 8,
  parameter int WIN      = 4,
  parameter int TOGGLE_N = 3
) (
  input logic              CLK,
  input logic              RST,
  jk_edge_monitor_if.slave bus
);
  localparam int GW = $clog2(WIN + 2);
  localparam int EW = $clog2(TOGGLE_N + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GW-1:0] GAP_MAX = GW'(WIN + 1);
  localparam logic [GW-1:0] GAP_WIN = GW'(WIN);
  localparam logic [EW-1:0] EC_TGT = EW'(TOGGLE_N);
  localparam logic [EW-1:0] EC_ONE = EW'(1);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_t;

  logic             r_q_s1;
  logic             r_q_s2;
  logic             r_q_s3;
  logic             r_qn_s1;
  logic             r_qn_s2;
  logic [1:0]       r_fill;
  logic             r_primed;
  logic             r_eq;
  logic             r_err;
  logic             r_rise_p;
  logic             r_fall_p;
  logic [CNT_W-1:0] r_rise_cnt;
  logic [CNT_W-1:0] r_fall_cnt;

  state_t           r_state;
  logic [GW-1:0]    r_gap;
  logic [EW-1:0]    r_ec;
  logic             r_tog;

  state_t           w_state_nx;
  logic [GW-1:0]    w_gap_nx;
  logic [EW-1:0]    w_ec_nx;
  logic [GW-1:0]    w_gap_inc;
  logic [EW-1:0]    w_ec_inc;
  logic             w_in_win;
  logic             w_s2_vld;
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_eq;

  // r_fill counts how far valid post-reset data has
  // propagated; s2 is trustworthy once it reaches 2.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q_s1   <= 1'b0;
      r_q_s2   <= 1'b0;
      r_q_s3   <= 1'b0;
      r_qn_s1  <= 1'b0;
      r_qn_s2  <= 1'b0;
      r_fill   <= 2'd0;
      r_primed <= 1'b0;
    end else begin
      r_q_s1   <= bus.Q_IN;
      r_q_s2   <= r_q_s1;
      r_q_s3   <= r_q_s2;
      r_qn_s1  <= bus.Q_N_IN;
      r_qn_s2  <= r_qn_s1;
      if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
      r_primed <= (r_fill == 2'd2);
    end
  end

  assign w_s2_vld = (r_fill == 2'd2);
  assign w_rise   = r_primed & r_q_s2 & ~r_q_s3;
  assign w_fall   = r_primed & ~r_q_s2 & r_q_s3;
  assign w_edge   = w_rise | w_fall;
  assign w_eq     = w_s2_vld & (r_q_s2 == r_qn_s2);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rise_p   <= 1'b0;
      r_fall_p   <= 1'b0;
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
      r_eq       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rise_p <= w_rise;
      r_fall_p <= w_fall;
      r_eq     <= w_eq;
      if (bus.CLR) begin
        r_rise_cnt <= '0;
        r_fall_cnt <= '0;
        r_err      <= 1'b0;
      end else begin
        if (w_rise && r_rise_cnt != CNT_MAX)
          r_rise_cnt <= r_rise_cnt + 1'b1;
        if (w_fall && r_fall_cnt != CNT_MAX)
          r_fall_cnt <= r_fall_cnt + 1'b1;
        // one equal cycle is tolerated as switching skew
        if (w_eq && r_eq) r_err <= 1'b1;
      end
    end
  end

  assign w_gap_inc = (r_gap == GAP_MAX) ? r_gap : r_gap + 1'b1;
  assign w_ec_inc  = r_ec + 1'b1;
  assign w_in_win  = (r_gap <= GAP_WIN);

  always_comb begin
    w_state_nx = r_state;
    w_gap_nx   = w_gap_inc;
    w_ec_nx    = r_ec;
    unique case (1'b1)
      (r_state == IDLE): begin
        if (w_edge) begin
          w_gap_nx   = '0;
          w_ec_nx    = EC_ONE;
          w_state_nx = (EC_ONE >= EC_TGT) ? LOCKED : TRACK;
        end
      end
      (r_state == TRACK): begin
        if (w_edge) begin
          w_gap_nx = '0;
          if (w_in_win) begin
            w_ec_nx = w_ec_inc;
            if (w_ec_inc >= EC_TGT) w_state_nx = LOCKED;
          end else begin
            w_ec_nx = EC_ONE;
          end
        end else if (!w_in_win) begin
          w_state_nx = IDLE;
          w_ec_nx    = '0;
        end
      end
      (r_state == LOCKED): begin
        if (w_edge) begin
          w_gap_nx = '0;
        end else if (!w_in_win) begin
          w_state_nx = IDLE;
          w_ec_nx    = '0;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_gap_nx   = '0;
        w_ec_nx    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_gap   <= '0;
      r_ec    <= '0;
      r_tog   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gap   <= w_gap_nx;
      r_ec    <= w_ec_nx;
      r_tog   <= (w_state_nx == LOCKED);
    end
  end

  assign bus.RISE_CNT   = r_rise_cnt;
  assign bus.FALL_CNT   = r_fall_cnt;
  assign bus.RISE_P     = r_rise_p;
  assign bus.FALL_P     = r_fall_p;
  assign bus.TOGGLE_DET = r_tog;
  assign bus.ERR        = r_err;
endmodule

// File: tb/tb_jk_edge_monitor.sv
// Scoreboard bench for jk_edge_monitor (CNT_W=4, WIN=4,
// TOGGLE_N=3); a monitor pops one record per output pulse.
module tb_jk_edge_monitor;
  logic CLK;
  logic RST;

  jk_edge_monitor_if #(.CNT_W(4)) bus ();

  jk_edge_monitor #(
    .CNT_W   (4),
    .WIN     (4),
    .TOGGLE_N(3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct packed {
    logic       rise;
    logic [3:0] rc;
    logic [3:0] fc;
    logic       tcare;
    logic       tog;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_r = 0;
  int   exp_f = 0;
  logic q = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endfunction

  function automatic void push_edge(logic rise,
                                    logic tcare,
                                    logic tog);
    exp_t e;
    if (rise) exp_r = (exp_r == 15) ? 15 : exp_r + 1;
    else      exp_f = (exp_f == 15) ? 15 : exp_f + 1;
    e.rise  = rise;
    e.rc    = 4'(exp_r);
    e.fc    = 4'(exp_f);
    e.tcare = tcare;
    e.tog   = tog;
    sb.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_q(input logic v);
    q          = v;
    bus.Q_IN   = v;
    bus.Q_N_IN = ~v;
  endtask

  task automatic do_clr();
    bus.CLR = 1'b1;
    tick(1);
    bus.CLR = 1'b0;
    exp_r = 0;
    exp_f = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_rcnt"}, bus.RISE_CNT, 0);
    chk({tag, "_fcnt"}, bus.FALL_CNT, 0);
    chk({tag, "_rp"}, bus.RISE_P, 0);
    chk({tag, "_fp"}, bus.FALL_P, 0);
    chk({tag, "_tog"}, bus.TOGGLE_DET, 0);
    chk({tag, "_err"}, bus.ERR, 0);
  endtask

  task automatic do_reset(string tag);
    RST = 1'b1;
    tick(1);
    chk_zero(tag);
    tick(1);
    RST = 1'b0;
    sb.delete();
    exp_r = 0;
    exp_f = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      chk("excl", bus.RISE_P & bus.FALL_P, 0);
      if (bus.RISE_P || bus.FALL_P) begin
        if (sb.size() == 0) begin
          chk("unexp_pulse", {bus.RISE_P, bus.FALL_P}, 0);
        end else begin
          e = sb.pop_front();
          chk("p_rise", bus.RISE_P, e.rise);
          chk("p_fall", bus.FALL_P, !e.rise);
          chk("p_rcnt", bus.RISE_CNT, e.rc);
          chk("p_fcnt", bus.FALL_CNT, e.fc);
          if (e.tcare) chk("p_tog", bus.TOGGLE_DET, e.tog);
        end
      end
    end
  end

  initial begin : stim
    RST     = 1'b1;
    bus.CLR = 1'b0;
    set_q(1'b0);
    tick(2);
    chk_zero("rst0");
    RST = 1'b0;
    tick(4);

    // single rise: latency E1 -> pulse after E3 only
    set_q(1'b1);
    push_edge(1'b1, 1'b1, 1'b0);
    tick(1);
    chk("lat_e1", bus.RISE_P, 0);
    tick(1);
    chk("lat_e2", bus.RISE_P, 0);
    tick(1);
    chk("lat_e3", bus.RISE_P, 1);
    chk("lat_rcnt", bus.RISE_CNT, 1);
    chk("lat_fcnt", bus.FALL_CNT, 0);
    tick(1);
    chk("lat_e4", bus.RISE_P, 0);
    chk("lat_err", bus.ERR, 0);
    tick(10);

    // toggle every 2 cycles, 8 edges
    do_clr();
    for (int i = 0; i < 8; i++) begin
      set_q(~q);
      push_edge(q, 1'b1, (i >= 2));
      if (i < 7) tick(2);
    end
    tick(7);
    chk("tog_hold", bus.TOGGLE_DET, 1);
    tick(3);
    chk("tog_drop", bus.TOGGLE_DET, 0);
    chk("tog_rcnt", bus.RISE_CNT, 4);
    chk("tog_fcnt", bus.FALL_CNT, 4);

    // saturation with 20 rises and 20 falls
    do_clr();
    for (int i = 0; i < 20; i++) begin
      set_q(1'b0);
      push_edge(1'b0, 1'b0, 1'b0);
      tick(3);
      set_q(1'b1);
      push_edge(1'b1, 1'b0, 1'b0);
      tick(3);
    end
    tick(5);
    chk("sat_rcnt", bus.RISE_CNT, 15);
    chk("sat_fcnt", bus.FALL_CNT, 15);

    // CLR coincident with a detected rise
    set_q(1'b0);
    push_edge(1'b0, 1'b0, 1'b0);
    tick(5);
    set_q(1'b1);
    sb.push_back('{1'b1, 4'd0, 4'd0, 1'b0, 1'b0});
    exp_r = 0;
    exp_f = 0;
    tick(2);
    bus.CLR = 1'b1;
    tick(1);
    bus.CLR = 1'b0;
    chk("clr_rp", bus.RISE_P, 1);
    chk("clr_rcnt", bus.RISE_CNT, 0);
    chk("clr_fcnt", bus.FALL_CNT, 0);
    tick(5);

    // complement violation: 1 cycle ignored, 3 cycles sticky
    bus.Q_N_IN = 1'b1;
    tick(1);
    bus.Q_N_IN = 1'b0;
    tick(5);
    chk("err_1cyc", bus.ERR, 0);
    bus.Q_N_IN = 1'b1;
    tick(3);
    bus.Q_N_IN = 1'b0;
    tick(4);
    chk("err_3cyc", bus.ERR, 1);
    tick(5);
    chk("err_held", bus.ERR, 1);
    do_clr();
    chk("err_clr", bus.ERR, 0);

    // Q held high through reset: no spurious rise
    do_reset("rst1");
    tick(10);
    chk("hold_rcnt", bus.RISE_CNT, 0);
    chk("hold_rp", bus.RISE_P, 0);

    // reset while LOCKED with an edge in the synchronizer
    set_q(1'b0);
    push_edge(1'b0, 1'b1, 1'b0);
    tick(2);
    set_q(1'b1);
    push_edge(1'b1, 1'b1, 1'b0);
    tick(2);
    set_q(1'b0);
    push_edge(1'b0, 1'b1, 1'b1);
    tick(5);
    chk("lock_pre", bus.TOGGLE_DET, 1);
    set_q(1'b1);
    tick(1);
    do_reset("rst2");
    tick(10);
    chk("post_rcnt", bus.RISE_CNT, 0);
    chk("post_fcnt", bus.FALL_CNT, 0);
    chk("post_tog", bus.TOGGLE_DET, 0);

    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jk_edge_monitor.md
JK_EDGE_MONITOR -- requirements
Module: jk_edge_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of each edge counter.
REQ-002 Parameter WIN, default 4: maximum sampled cycles between edges that still count as toggling.
REQ-003 Parameter TOGGLE_N, default 3: number of consecutive in-window edges needed to declare toggle mode.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 Q_IN  input  1  JK flip-flop true output; may be asynchronous to CLK.
REQ-007 Q_N_IN  input  1  JK flip-flop complementary output; may be asynchronous to CLK.
REQ-008 CLR  input  1  synchronous clear of counters and ERR.
REQ-009 RISE_CNT  output  CNT_W  count of rising edges on Q_IN.
REQ-010 FALL_CNT  output  CNT_W  count of falling edges on Q_IN.
REQ-011 RISE_P  output  1  one-cycle pulse per detected rising edge.
REQ-012 FALL_P  output  1  one-cycle pulse per detected falling edge.
REQ-013 TOGGLE_DET  output  1  high while Q_IN is in toggle mode.
REQ-014 ERR  output  1  sticky complement-violation flag.

Function
REQ-015 Q_IN and Q_N_IN SHALL each pass through a 2-flop synchronizer (s1, s2); s3 holds the previous s2 value of Q_IN.
REQ-016 A rising edge SHALL be s2=1 & s3=0; a falling edge SHALL be s2=0 & s3=1.
REQ-017 Latency: when a Q_IN change is first sampled at edge E1, RISE_P/FALL_P SHALL be high after E3 and low after E4, and the counter SHALL update at E3.
REQ-018 The module SHALL keep a PRIMED flag, cleared by reset and set at the first edge after s2 holds valid post-reset data. No edge SHALL be reported while PRIMED=0, so a Q_IN held at 1 through reset gives no spurious RISE_P.
REQ-019 RISE_CNT/FALL_CNT SHALL increment by 1 per detected edge and saturate at 2^CNT_W-1, with no wrap-around.
REQ-020 CLR SHALL zero both counters and ERR at the next edge. CLR takes priority over a simultaneous edge: the count is 0, the pulse is still emitted, and TOGGLE_DET is unaffected.
REQ-021 The toggle FSM SHALL have states IDLE, TRACK and LOCKED, plus a gap counter GAP (0..WIN+1) and an edge counter EC (0..TOGGLE_N).
REQ-022 IDLE: any detected edge -> TRACK with EC=1 and GAP=0.
REQ-023 TRACK: an edge with GAP<=WIN -> EC+1 and GAP=0; when EC reaches TOGGLE_N -> LOCKED. GAP>WIN -> IDLE with EC=0.
REQ-024 LOCKED: an edge sets GAP=0; GAP>WIN -> IDLE.
REQ-025 TOGGLE_DET SHALL be a registered output that is 1 exactly while the state is LOCKED.
REQ-026 GAP SHALL increment each cycle with no edge, saturating at WIN+1.
REQ-027 ERR SHALL set when the synchronized Q and Q_N are equal for 2 consecutive cycles. It stays set until CLR or RST, and a single equal cycle (switching skew) SHALL NOT set it.
REQ-028 RISE_P and FALL_P SHALL never be high in the same cycle.

Reset
REQ-029 With RST=1 at a rising edge, all of the following SHALL be 0 after that edge: RISE_CNT, FALL_CNT, RISE_P, FALL_P, TOGGLE_DET, ERR, the synchronizers, PRIMED, GAP and EC; the FSM SHALL be in IDLE.
REQ-030 RST asserted mid-operation, for example in LOCKED with pulses in flight, SHALL discard all in-flight edges. No pulse SHALL appear in the cycle after reset.
REQ-031 RST SHALL take priority over CLR and over edge detection.

Verification
REQ-032 Reset, then Q_IN=0 and Q_N_IN=1; raise Q_IN and lower Q_N_IN before edge E1 -> RISE_P=1 after E3 only, RISE_CNT=1, FALL_CNT=0, ERR=0.
REQ-033 Q_IN=1 held through RST deassertion -> no RISE_P for 10 cycles, RISE_CNT=0.
REQ-034 Toggle Q_IN every 2 cycles for 8 edges (WIN=4, TOGGLE_N=3) -> TOGGLE_DET=1 one cycle after the 3rd detected edge, RISE_CNT=4, FALL_CNT=4. Then hold Q_IN -> TOGGLE_DET=0 once GAP exceeds 4.
REQ-035 CNT_W=4 with 20 rising edges -> RISE_CNT holds 15. CLR coincident with an edge -> RISE_CNT=0 and RISE_P=1.
REQ-036 Q_IN=Q_N_IN=1 for 1 cycle -> ERR=0. The same condition for 3 cycles -> ERR=1, held until CLR.
REQ-037 RST asserted while LOCKED with an edge in the synchronizer -> all outputs 0 the next cycle, no pulse afterwards, FSM in IDLE.
